// File: rtl/lcd12864_frame_sequencer.sv
// Init/frame byte sequencer feeding the 10-bit SPI writer of a 128x64 ST7565-class LCD.
// Define LCD_AUTO_REFRESH_EN for continuous redraw instead of waiting for Refresh_Req.
module lcd12864_frame_sequencer #(
  parameter logic [23:0] INIT_DELAY = 24'd50000,
  parameter logic [7:0]  CONTRAST   = 8'h28
) (
  input  logic       CLOCK,
  input  logic       RST,
  input  logic       Refresh_Req,
  input  logic       Done_Sig,
  output logic       Start_Sig,
  output logic [9:0] SPI_Data,
  output logic [9:0] Rd_Addr,
  input  logic [7:0] Rd_Data,
  output logic       Busy,
  output logic       Frame_Done
);

  typedef enum logic [2:0] {StWait, StInit, StPageHdr, StFetch, StData, StIdle} state_e;
  // PhTail: Start held one cycle past Done; PhLoad: gap cycle then byte load; PhRun: Start high
  typedef enum logic [1:0] {PhLoad, PhRun, PhTail} phase_e;

  state_e      state_q, state_d;
  phase_e      phase_q, phase_d;
  logic [23:0] delay_cnt_q, delay_cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [2:0]  page_q, page_d;
  logic [6:0]  col_q, col_d;
  logic        start_q, start_d;
  logic [9:0]  spi_data_q, spi_data_d;
  logic [9:0]  rd_addr_q, rd_addr_d;
  logic        frame_done_q, frame_done_d;

  logic [7:0]  init_byte;
  logic [7:0]  hdr_byte;
  logic [7:0]  cmd_byte;
  logic        byte_done;

  always_comb begin
    unique case (idx_q)
      3'd0:    init_byte = 8'hE2;
      3'd1:    init_byte = 8'hA2;
      3'd2:    init_byte = 8'hA0;
      3'd3:    init_byte = 8'hC8;
      3'd4:    init_byte = 8'h2F;
      3'd5:    init_byte = 8'h81;
      3'd6:    init_byte = CONTRAST;
      default: init_byte = 8'hAF;
    endcase
  end

  always_comb begin
    unique case (idx_q)
      3'd0:    hdr_byte = {5'b1011_0, page_q};
      3'd1:    hdr_byte = 8'h10;
      default: hdr_byte = 8'h00;
    endcase
  end

  assign cmd_byte  = (state_q == StInit) ? init_byte : hdr_byte;
  // Done only counts while the writer is actually enabled.
  assign byte_done = start_q && Done_Sig && (phase_q == PhRun);

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    delay_cnt_d  = delay_cnt_q;
    idx_d        = idx_q;
    page_d       = page_q;
    col_d        = col_q;
    start_d      = start_q;
    spi_data_d   = spi_data_q;
    rd_addr_d    = rd_addr_q;
    frame_done_d = 1'b0;

    unique case (state_q)
      StWait: begin
        if (delay_cnt_q == INIT_DELAY - 24'd1) begin
          state_d = StInit;
          phase_d = PhLoad;
          idx_d   = 3'd0;
        end else begin
          delay_cnt_d = delay_cnt_q + 24'd1;
        end
      end

      StInit, StPageHdr: begin
        unique case (phase_q)
          PhTail: begin
            start_d = 1'b0;
            phase_d = PhLoad;
          end
          PhLoad: begin
            spi_data_d = {2'b00, cmd_byte};
            phase_d    = PhRun;
          end
          default: begin
            start_d = 1'b1;
            if (byte_done) begin
              phase_d = PhTail;
              if (state_q == StInit) begin
                if (idx_q == 3'd7) begin
                  state_d = StPageHdr;
                  idx_d   = 3'd0;
                  page_d  = 3'd0;
                end else begin
                  idx_d = idx_q + 3'd1;
                end
              end else if (idx_q == 3'd2) begin
                state_d   = StFetch;
                col_d     = 7'd0;
                rd_addr_d = {page_q, 7'd0};
              end else begin
                idx_d = idx_q + 3'd1;
              end
            end
          end
        endcase
      end

      StFetch: begin
        if (phase_q == PhTail) begin
          // Rd_Addr changed on entry; this cycle is both the Start tail and the read latency.
          start_d = 1'b0;
          phase_d = PhLoad;
        end else begin
          spi_data_d = {2'b01, Rd_Data};
          state_d    = StData;
          phase_d    = PhRun;
        end
      end

      StData: begin
        start_d = 1'b1;
        if (byte_done) begin
          phase_d = PhTail;
          if (col_q != 7'd127) begin
            col_d     = col_q + 7'd1;
            rd_addr_d = {page_q, col_q + 7'd1};
            state_d   = StFetch;
          end else if (page_q != 3'd7) begin
            page_d  = page_q + 3'd1;
            idx_d   = 3'd0;
            state_d = StPageHdr;
          end else begin
            frame_done_d = 1'b1;
`ifdef LCD_AUTO_REFRESH_EN
            page_d  = 3'd0;
            idx_d   = 3'd0;
            state_d = StPageHdr;
`else
            state_d = StIdle;
`endif
          end
        end
      end

      StIdle: begin
        start_d    = 1'b0;
        spi_data_d = 10'h300;
        phase_d    = PhLoad;
        if (Refresh_Req) begin
          page_d  = 3'd0;
          idx_d   = 3'd0;
          state_d = StPageHdr;
        end
      end

      default: state_d = StWait;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RST) begin
      state_q      <= StWait;
      phase_q      <= PhLoad;
      delay_cnt_q  <= 24'd0;
      idx_q        <= 3'd0;
      page_q       <= 3'd0;
      col_q        <= 7'd0;
      start_q      <= 1'b0;
      spi_data_q   <= 10'h300;
      rd_addr_q    <= 10'd0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      delay_cnt_q  <= delay_cnt_d;
      idx_q        <= idx_d;
      page_q       <= page_d;
      col_q        <= col_d;
      start_q      <= start_d;
      spi_data_q   <= spi_data_d;
      rd_addr_q    <= rd_addr_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign Start_Sig  = start_q;
  assign SPI_Data   = spi_data_q;
  assign Rd_Addr    = rd_addr_q;
  assign Frame_Done = frame_done_q;
  assign Busy       = (state_q != StIdle);

endmodule

// File: tb/tb_lcd12864_frame_sequencer.sv
// Directed bench for lcd12864_frame_sequencer with an SPI-writer responder and a ramp frame buffer.
module tb_lcd12864_frame_sequencer;

  logic       CLOCK;
  logic       RST;
  logic       Refresh_Req;
  logic       Done_Sig;
  logic       Start_Sig;
  logic [9:0] SPI_Data;
  logic [9:0] Rd_Addr;
  logic [7:0] Rd_Data;
  logic       Busy;
  logic       Frame_Done;

  int checks = 0;
  int errors = 0;

  lcd12864_frame_sequencer #(
    .INIT_DELAY (24'd10),
    .CONTRAST   (8'h28)
  ) dut (
    .CLOCK       (CLOCK),
    .RST         (RST),
    .Refresh_Req (Refresh_Req),
    .Done_Sig    (Done_Sig),
    .Start_Sig   (Start_Sig),
    .SPI_Data    (SPI_Data),
    .Rd_Addr     (Rd_Addr),
    .Rd_Data     (Rd_Data),
    .Busy        (Busy),
    .Frame_Done  (Frame_Done)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  // Writer model: Done pulse 34 cycles after Start rises; buffer data valid one cycle after address.
  logic [5:0] wcnt;
  always @(posedge CLOCK) begin
    Rd_Data <= Rd_Addr[7:0];
    if (RST || !Start_Sig) begin
      wcnt     <= 6'd0;
      Done_Sig <= 1'b0;
    end else begin
      wcnt     <= (wcnt == 6'd63) ? wcnt : wcnt + 6'd1;
      Done_Sig <= (wcnt == 6'd33);
    end
  end

  // Byte log and handshake monitor, sampled on the falling edge.
  logic [9:0] byte_log [0:2047];
  logic [9:0] addr_log [0:2047];
  int   nbytes = 0;
  int   stable_viol = 0;
  int   tail_viol = 0;
  int   gap_viol = 0;
  int   tail_st = 0;
  int   low_len = 0;
  logic start_prev = 1'b0;
  logic [9:0] data_prev = 10'h300;
  logic after_done = 1'b0;
  logic saw_idle = 1'b0;

  always @(negedge CLOCK) begin
    if (RST) begin
      tail_st    = 0;
      low_len    = 0;
      after_done = 1'b0;
      saw_idle   = 1'b0;
    end else begin
      if (Start_Sig && start_prev && (SPI_Data !== data_prev)) stable_viol++;
      if (tail_st == 1) begin
        if (Start_Sig !== 1'b1) tail_viol++;
        tail_st = 2;
      end else if (tail_st == 2) begin
        if (Start_Sig !== 1'b0) tail_viol++;
        tail_st = 0;
      end
      if (Done_Sig === 1'b1) begin
        tail_st    = 1;
        after_done = 1'b1;
      end
      if (!Start_Sig) begin
        low_len++;
        if (!Busy) saw_idle = 1'b1;
      end else if (!start_prev) begin
        // Between bytes: one gap cycle plus one load cycle with Start low.
        if (after_done && !saw_idle && low_len != 2) gap_viol++;
        if (nbytes < 2048) begin
          byte_log[nbytes] = SPI_Data;
          addr_log[nbytes] = Rd_Addr;
        end
        nbytes++;
        low_len  = 0;
        saw_idle = 1'b0;
      end
    end
    start_prev = Start_Sig;
    data_prev  = SPI_Data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CLOCK);
  endtask

  task automatic wait_bytes(input int target, input string tag);
    int k = 0;
    while (nbytes < target && k < 60000) begin
      @(negedge CLOCK);
      k++;
    end
    checks++;
    assert (nbytes >= target)
    else begin
      errors++;
      $error("FAIL %s: byte count %0d required at least %0d", tag, nbytes, target);
    end
  endtask

  logic [7:0] init_exp [0:7];
  int base;
  int k;

  initial begin
    init_exp[0] = 8'hE2; init_exp[1] = 8'hA2; init_exp[2] = 8'hA0; init_exp[3] = 8'hC8;
    init_exp[4] = 8'h2F; init_exp[5] = 8'h81; init_exp[6] = 8'h28; init_exp[7] = 8'hAF;
    RST         = 1'b1;
    Refresh_Req = 1'b0;

    step(2);
    check("rst_start", 32'(Start_Sig), 32'd0);
    check("rst_spi", 32'(SPI_Data), 32'h300);
    check("rst_addr", 32'(Rd_Addr), 32'd0);
    check("rst_busy", 32'(Busy), 32'd1);
    check("rst_fdone", 32'(Frame_Done), 32'd0);

    RST = 1'b0;
    // Edge 11 loads the first command, edge 12 raises Start.
    step(11);
    check("first_load_start", 32'(Start_Sig), 32'd0);
    check("first_load_data", 32'(SPI_Data), 32'h0E2);
    step(1);
    check("first_rise", 32'(Start_Sig), 32'd1);

    wait_bytes(8, "init_count");
    for (int i = 0; i < 8; i++) check($sformatf("init_%0d", i), 32'(byte_log[i]),
                                     32'({2'b00, init_exp[i]}));

    // Page 3 occupies bytes 401..531: header then 128 data bytes.
    wait_bytes(532, "page3_count");
    check("p3_hdr0", 32'(byte_log[401]), 32'h0B3);
    check("p3_hdr1", 32'(byte_log[402]), 32'h010);
    check("p3_hdr2", 32'(byte_log[403]), 32'h000);
    for (int c = 0; c < 128; c++) begin
      check($sformatf("p3_data_%0d", c), 32'(byte_log[404 + c]), 32'(10'h180 + 10'(c)));
      check($sformatf("p3_addr_%0d", c), 32'(addr_log[404 + c]), 32'(10'h180 + 10'(c)));
    end

    k = 0;
    while (Frame_Done !== 1'b1 && k < 60000) begin
      @(negedge CLOCK);
      k++;
    end
    check("frame_done_seen", 32'(Frame_Done), 32'd1);
    check("frame_bytes", 32'(nbytes), 32'd1056);
    check("frame_tail_start", 32'(Start_Sig), 32'd1);
`ifdef LCD_AUTO_REFRESH_EN
    check("auto_busy", 32'(Busy), 32'd1);
    step(1);
    check("fdone_pulse", 32'(Frame_Done), 32'd0);
    step(1);
    check("auto_b0_data", 32'(SPI_Data), 32'h0B0);
    step(5);
    check("auto_busy_later", 32'(Busy), 32'd1);
    wait_bytes(1059, "auto_hdr_count");
    check("auto_hdr0", 32'(byte_log[1056]), 32'h0B0);
`else
    check("idle_busy", 32'(Busy), 32'd0);
    step(1);
    check("fdone_pulse", 32'(Frame_Done), 32'd0);
    check("idle_start", 32'(Start_Sig), 32'd0);
    check("idle_spi", 32'(SPI_Data), 32'h300);
    step(5);
    check("idle_hold", 32'(Start_Sig), 32'd0);
    check("idle_no_bytes", 32'(nbytes), 32'd1056);
    Refresh_Req = 1'b1;
    step(1);
    Refresh_Req = 1'b0;
    wait_bytes(1059, "refresh_count");
    check("refresh_hdr0", 32'(byte_log[1056]), 32'h0B0);
    check("refresh_hdr1", 32'(byte_log[1057]), 32'h010);
    check("refresh_hdr2", 32'(byte_log[1058]), 32'h000);
`endif

    // Second frame page 5 data starts at byte 1056 + 5*131 + 3 = 1714.
    wait_bytes(1720, "page5_count");
    check("page5_addr", 32'(Rd_Addr[9:7]), 32'd5);
    check("hs_stable", 32'(stable_viol), 32'd0);
    check("hs_tail", 32'(tail_viol), 32'd0);
    check("hs_gap", 32'(gap_viol), 32'd0);
    #1 RST = 1'b1;
    step(1);
    check("midrst_start", 32'(Start_Sig), 32'd0);
    check("midrst_spi", 32'(SPI_Data), 32'h300);
    check("midrst_busy", 32'(Busy), 32'd1);
    #1 RST = 1'b0;
    base = nbytes;
    wait_bytes(base + 8, "reinit_count");
    check("reinit_first", 32'(byte_log[base]), 32'h0E2);
    check("reinit_contrast", 32'(byte_log[base + 6]), 32'h028);
    check("reinit_last", 32'(byte_log[base + 7]), 32'h0AF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
